// File: rtl/axi_pkt_hold_pkg.sv
// Shared types and constants for the packet-hold buffer: write FSM encoding
// and pointer-width helpers (pointers carry one wrap bit above the address).
package axi_pkt_hold_pkg;

    typedef enum logic {
        ST_WRITE   = 1'b0,
        ST_DISCARD = 1'b1
    } wr_state_t;

    localparam int PTR_GUARD_BITS = 1;

    function automatic int ptr_width(input int size);
        return size + PTR_GUARD_BITS;
    endfunction

endpackage

// File: rtl/axi_pkt_hold_ram.sv
// Simple dual-port RAM: one write port, one synchronous-read port. The read
// register only updates on re, so it doubles as a hold stage for the reader.
module axi_pkt_hold_ram #(
    parameter int DW = 33,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1<<AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_pkt_hold.sv
// Packet-hold FIFO: beats are only released once their whole packet is in.
// Define AXI_PKT_HOLD_DROP_EN to add i_terror and drop packets flagged bad.
module axi_pkt_hold
    import axi_pkt_hold_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
`ifdef AXI_PKT_HOLD_DROP_EN
    input  logic             i_terror,
`endif
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [SIZE:0]    pkt_count,
    output logic             overflow
);

    localparam int PW    = ptr_width(SIZE);
    localparam int DEPTH = 1 << SIZE;

    wr_state_t        state;
    logic [PW-1:0]    wr_ptr, commit_ptr, rd_ptr, pf_ptr;
    logic [PW-1:0]    used;
    logic             flush, full, in_hs, out_hs, we, commit, terr;
    logic             pf_vld, out_ld, rd_en;
    logic [WIDTH:0]   ram_q;

`ifdef AXI_PKT_HOLD_DROP_EN
    assign terr = i_terror;
`else
    assign terr = 1'b0;
`endif

    assign flush    = reset | clear;
    // rd_ptr marks beats actually handed downstream, so prefetched beats
    // still occupy space until the output handshake.
    assign used     = wr_ptr - rd_ptr;
    assign full     = (used == PW'(DEPTH));
    assign i_tready = !flush && (state == ST_DISCARD || !full);
    assign in_hs    = i_tvalid && i_tready;
    assign we       = in_hs && (state == ST_WRITE);
    assign commit   = we && i_tlast && !terr;
    assign out_hs   = o_tvalid && o_tready;

    always_ff @(posedge clk) begin
        if (flush) begin
            state      <= ST_WRITE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                ST_WRITE: begin
                    if (full && commit_ptr == rd_ptr) begin
                        // Buffer is entirely this one packet: it can never fit.
                        state    <= ST_DISCARD;
                        wr_ptr   <= commit_ptr;
                        overflow <= 1'b1;
                    end else if (in_hs) begin
                        if (i_tlast && terr) begin
                            wr_ptr <= commit_ptr;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                            if (i_tlast) commit_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                ST_DISCARD: begin
                    if (in_hs && i_tlast) state <= ST_WRITE;
                end
                default: state <= ST_WRITE;
            endcase
        end
    end

    // Two-deep read pipe: RAM read register (pf_vld) feeding the output register.
    assign out_ld = pf_vld && (!o_tvalid || o_tready);
    assign rd_en  = (pf_ptr != commit_ptr) && (!pf_vld || out_ld);

    axi_pkt_hold_ram #(.DW(WIDTH + 1), .AW(SIZE)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[SIZE-1:0]),
        .wdata ({i_tlast, i_tdata}),
        .re    (rd_en),
        .raddr (pf_ptr[SIZE-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            pf_ptr    <= '0;
            rd_ptr    <= '0;
            pf_vld    <= 1'b0;
            o_tvalid  <= 1'b0;
            o_tdata   <= '0;
            o_tlast   <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (rd_en) pf_ptr <= pf_ptr + PW'(1);
            if (out_hs) rd_ptr <= rd_ptr + PW'(1);
            if (rd_en)       pf_vld <= 1'b1;
            else if (out_ld) pf_vld <= 1'b0;
            if (out_ld) begin
                o_tvalid <= 1'b1;
                {o_tlast, o_tdata} <= ram_q;
            end else if (o_tready) begin
                o_tvalid <= 1'b0;
            end
            pkt_count <= pkt_count + PW'(commit) - PW'(out_hs && o_tlast);
        end
    end

endmodule

// File: tb/tb_axi_pkt_hold.sv
// Self-checking bench for axi_pkt_hold (SIZE=4): directed cases plus random
// traffic scored against a queue of committed packets.
module tb_axi_pkt_hold;

    localparam int WIDTH = 16;
    localparam int SIZE  = 4;

    logic             clk = 1'b0;
    logic             reset, clear;
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast, i_tvalid, i_tready, i_terror;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast, o_tvalid, o_tready;
    logic [SIZE:0]    pkt_count;
    logic             overflow;

    always #5 clk = ~clk;

    axi_pkt_hold #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
`ifdef AXI_PKT_HOLD_DROP_EN
        .i_terror  (i_terror),
`endif
        .o_tdata   (o_tdata),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .pkt_count (pkt_count),
        .overflow  (overflow)
    );

    int n_vec = 0;
    int n_err = 0;
    int ovf_cnt = 0;
    bit rdy_rand = 0;
    logic [WIDTH:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int held_pkts();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][WIDTH]) n++;
        return n;
    endfunction

    // Output scoreboard: inputs settle after posedge, so the negedge sees
    // exactly what the next posedge will sample.
    bit             stalled = 0;
    logic [WIDTH:0] stall_beat;
    always @(negedge clk) begin
        if (reset || clear) begin
            stalled = 0;
        end else begin
            if (overflow) ovf_cnt++;
            check("pkt_count", 64'(pkt_count), 64'(held_pkts()));
            if (stalled) check("hold", {47'd0, o_tvalid, o_tlast, o_tdata}, {47'd0, 1'b1, stall_beat});
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) check("extra_beat", {47'd0, o_tlast, o_tdata}, 64'hdead);
                else check("beat", {47'd0, o_tlast, o_tdata}, 64'(exp_q.pop_front()));
            end
            stalled = o_tvalid && !o_tready;
            stall_beat = {o_tlast, o_tdata};
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rdy_rand) o_tready = ($urandom_range(1, 0) == 1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_hs();
        bit hs;
        for (int t = 0; ; t++) begin
            @(negedge clk); hs = i_tready;
            tick();
            if (hs) break;
            if (t > 2000) begin
                check("hs_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic send_pkt(input int len, input bit err, input bit keep, input int gap_max);
        logic [WIDTH:0] beats[$];
        logic [WIDTH-1:0] d;
        for (int b = 0; b < len; b++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin i_tvalid = 0; tick(); end
            d = WIDTH'($urandom);
            i_tvalid = 1; i_tdata = d; i_tlast = (b == len - 1); i_terror = err && (b == len - 1);
            wait_hs();
            beats.push_back({i_tlast, d});
        end
        i_tvalid = 0; i_tlast = 0; i_terror = 0;
        if (keep) foreach (beats[i]) exp_q.push_back(beats[i]);
    endtask

    task automatic drain();
        for (int t = 0; exp_q.size() != 0 || o_tvalid; t++) begin
            if (t > 3000) begin check("drain_timeout", 64'(exp_q.size()), 64'd0); break; end
            tick();
        end
    endtask

    initial begin
        int ovf0;
        reset = 1; clear = 0; i_tdata = '0; i_tlast = 0; i_tvalid = 0; i_terror = 0; o_tready = 1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tready", 64'(i_tready), 64'd0);
        tick(); reset = 0;
        @(negedge clk);
        check("rst_state", {45'd0, o_tvalid, o_tlast, o_tdata, pkt_count, overflow}, 64'd0);
        check("rdy_after_rst", 64'(i_tready), 64'd1);
        tick();

        // 3-beat packet latency: valid exactly two cycles after the tlast handshake
        send_pkt(3, 0, 1, 0);
        @(negedge clk); check("lat0", 64'(o_tvalid), 64'd0); check("cnt_one", 64'(pkt_count), 64'd1);
        @(negedge clk); check("lat1", 64'(o_tvalid), 64'd0);
        @(negedge clk); check("lat2", 64'(o_tvalid), 64'd1);
        tick(); drain();
        check("cnt_zero", 64'(pkt_count), 64'd0);

        // Fill to depth with the output stalled, then free one slot
        o_tready = 0;
        repeat (4) send_pkt(4, 0, 1, 0);
        @(negedge clk);
        check("full_tready", 64'(i_tready), 64'd0);
        check("full_cnt", 64'(pkt_count), 64'd4);
        tick(); o_tready = 1;
        tick(); o_tready = 0;
        @(negedge clk);
        check("freed_tready", 64'(i_tready), 64'd1);
        check("freed_cnt", 64'(pkt_count), 64'd4);
        tick(); o_tready = 1; drain();

        // Oversized packet is discarded with a single overflow pulse
        ovf0 = ovf_cnt;
        send_pkt(20, 0, 0, 0);
        @(negedge clk);
        check("ovf_once", 64'(ovf_cnt - ovf0), 64'd1);
        check("ovf_cnt", 64'(pkt_count), 64'd0);
        tick();
        send_pkt(2, 0, 1, 0);
        drain();

`ifdef AXI_PKT_HOLD_DROP_EN
        send_pkt(2, 0, 1, 0);
        send_pkt(3, 1, 0, 0);
        send_pkt(2, 0, 1, 0);
        drain();
        check("err_no_ovf", 64'(ovf_cnt - ovf0), 64'd1);
`endif

        // clear drops held packets
        o_tready = 0;
        send_pkt(3, 0, 1, 0);
        clear = 1; exp_q.delete();
        tick(); clear = 0;
        @(negedge clk);
        check("clr_vld", 64'(o_tvalid), 64'd0);
        check("clr_cnt", 64'(pkt_count), 64'd0);
        tick();

        // Reset during 2nd beat with one packet held
        send_pkt(2, 0, 1, 0);
        i_tvalid = 1; i_tdata = 16'h1111; i_tlast = 0;
        wait_hs();
        i_tdata = 16'h2222; reset = 1; exp_q.delete();
        @(negedge clk);
        check("rst_mid_tready", 64'(i_tready), 64'd0);
        tick(); reset = 0; i_tvalid = 0;
        @(negedge clk);
        check("rst_mid_vld", 64'(o_tvalid), 64'd0);
        check("rst_mid_cnt", 64'(pkt_count), 64'd0);
        tick(); o_tready = 1;
        send_pkt(3, 0, 1, 0);
        drain();

        // Random traffic
        ovf0 = ovf_cnt;
        rdy_rand = 1;
        for (int p = 0; p < 1000; p++) send_pkt($urandom_range(16, 1), 0, 1, 2);
        rdy_rand = 0; tick(); o_tready = 1;
        drain();
        check("rand_no_ovf", 64'(ovf_cnt - ovf0), 64'd0);
        check("rand_cnt", 64'(pkt_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_pkt_hold.md
AXI_PKT_HOLD -- requirements
Module: axi_pkt_hold

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the payload bit width of tdata.
REQ-002 SHALL have parameter SIZE, default 10, meaning log2 of buffer depth in beats (depth 2**SIZE, SIZE >= 2).
REQ-003 SHALL have one clock and a synchronous active-high reset: clk input 1 (sole clock); reset input 1 (synchronous, active-high).
REQ-004 SHALL have port clear, input, 1 bit: synchronous flush, same effect as reset.
REQ-005 SHALL have ports i_tdata input WIDTH, i_tlast input 1, i_tvalid input 1, i_tready output 1: upstream AXI-Stream.
REQ-006 SHALL have port i_terror, input, 1 bit: packet-bad flag, sampled only on the accepted tlast beat (present only with AXI_PKT_HOLD_DROP_EN).
REQ-007 SHALL have ports o_tdata output WIDTH, o_tlast output 1, o_tvalid output 1, o_tready input 1: downstream AXI-Stream feeding axi_fifo_2clk.
REQ-008 SHALL have port pkt_count, output, SIZE+1 bits: number of complete packets held.
REQ-009 SHALL have port overflow, output, 1 bit: one-cycle pulse when a packet is discarded for exceeding depth.

Function
REQ-010 SHALL store {tlast, tdata} beats in a 2**SIZE x (WIDTH+1) simple-dual-port RAM with synchronous read.
REQ-011 SHALL keep SIZE+1-bit pointers wr_ptr, commit_ptr and rd_ptr; full when wr_ptr - rd_ptr == 2**SIZE; pointers wrap modulo 2**(SIZE+1).
REQ-012 SHALL release beats only from complete packets: a beat is readable only while rd_ptr != commit_ptr.
REQ-013 SHALL use write state machine WRITE/DISCARD; reset state WRITE.
REQ-014 In WRITE, i_tready SHALL be 1 when not full; each handshake writes RAM[wr_ptr] and increments wr_ptr.
REQ-015 On an accepted tlast beat (no error), commit_ptr SHALL become wr_ptr+1 and pkt_count SHALL increment, both visible the next cycle.
REQ-016 WRITE->DISCARD SHALL occur when full and commit_ptr == rd_ptr (packet larger than depth): wr_ptr rewinds to commit_ptr and overflow pulses.
REQ-017 In DISCARD, i_tready SHALL be 1, beats SHALL be dropped, and the accepted tlast beat SHALL return the state to WRITE with no commit.
REQ-018 Output SHALL be a one-entry register stage with read prefetch; the first beat of a packet SHALL be valid on o_tvalid two cycles after its tlast handshake, given an empty output stage.
REQ-019 o_tvalid SHALL stay asserted with stable o_tdata/o_tlast until o_tready; back-to-back beats SHALL sustain one beat per cycle.
REQ-020 pkt_count SHALL decrement on an output handshake with o_tlast=1; simultaneous commit and release SHALL leave it unchanged.
REQ-021 i_tready SHALL not depend combinationally on i_tvalid; o_tvalid SHALL not depend combinationally on o_tready.

Reset
REQ-022 On reset or clear: pointers 0, state WRITE, i_tready 0 for that cycle then per REQ-014, o_tvalid 0, o_tdata 0, o_tlast 0, pkt_count 0, overflow 0.
REQ-023 Reset or clear mid-packet SHALL discard both the partial input packet and all held packets; RAM contents need not be cleared.

Configuration
REQ-024 Macro AXI_PKT_HOLD_DROP_EN defined: i_terror exists; a tlast beat with i_terror=1 SHALL rewind wr_ptr to commit_ptr, no commit, no pkt_count change, no overflow pulse.
REQ-025 Macro undefined: i_terror port absent; every tlast commits.

Structure
REQ-026 Package axi_pkt_hold_pkg SHALL hold the state encoding (ST_WRITE, ST_DISCARD) and pointer-width helper constants.
REQ-027 RAM SHALL be sub-module axi_pkt_hold_ram (WIDTH+1 bits, 2**SIZE deep, synchronous read, one write and one read port).

Verification
REQ-028 SIZE=4: 3-beat packet A1,A2,A3 (tlast on A3) -> o_tvalid low until 2 cycles after A3 handshake; out A1,A2,A3, tlast on A3; pkt_count 1->0.
REQ-029 SIZE=4, o_tready=0: 16 beats as four 4-beat packets -> i_tready 0 after 16th beat, pkt_count 4; one read raises i_tready.
REQ-030 SIZE=4: 20-beat packet into empty buffer -> overflow pulses once, beats dropped through tlast, pkt_count 0; next 2-beat packet delivered intact.
REQ-031 DROP_EN: packet B (3 beats) with i_terror=1 on tlast between good packets A and C -> output A then C only, pkt_count never counts B.
REQ-032 Reset asserted mid-way through 2nd beat of a packet with one complete packet held -> o_tvalid 0, pkt_count 0 next cycle; subsequent packet delivered correctly.
REQ-033 Random o_tready and i_tvalid, 1000 random-length packets -> output sequence equals input sequence, no beat loss or duplication.
